// File: rtl/retire_check_pkg.sv
// Shared types and constants for the retire-stream checker.
// State and fail-code encodings stay fixed widths so scripts can decode them.
package retire_check_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int PC_W   = 32;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_PASS = 2'd2;
    localparam state_t ST_FAIL = 2'd3;

    typedef logic [2:0] fail_code_t;
    localparam fail_code_t FAIL_NONE       = 3'd0;
    localparam fail_code_t FAIL_MISMATCH   = 3'd1;
    localparam fail_code_t FAIL_UNEXPECTED = 3'd2;
    localparam fail_code_t FAIL_TIMEOUT    = 3'd3;
    localparam fail_code_t FAIL_LEFTOVER   = 3'd4;
    localparam fail_code_t FAIL_OVERFLOW   = 3'd5;

endpackage

// File: rtl/retire_exp_fifo.sv
// Expected-result FIFO: wrap-bit pointers, head visible combinationally.
// Pushes while full and pops while empty are dropped.
module retire_exp_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    // Same slot index but different lap bit means the writer is a full lap ahead.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/retire_checker.sv
// In-order checker of the CPU writeback stream against a bench-loaded queue.
// Reports the first failure only; PASS/FAIL hold until reset.
module retire_checker
    import retire_check_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int TIMEOUT   = 64,
    parameter int IGNORE_R0 = 1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              exp_push,
    input  logic [REG_W-1:0]  exp_reg,
    input  logic [DATA_W-1:0] exp_data,
    output logic              exp_full,
    input  logic              start,
    input  logic              end_of_test,
    input  logic              ret_valid,
    input  logic [PC_W-1:0]   ret_pc,
    input  logic [REG_W-1:0]  ret_reg,
    input  logic [DATA_W-1:0] ret_data,
    output logic [15:0]       pass_count,
    output logic [2:0]        fail_code,
    output logic [PC_W-1:0]   fail_pc,
    output logic              done,
    output logic              error
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    state_t                    state;
    logic [WW-1:0]             wd;
    logic [REG_W+DATA_W-1:0]   head;
    logic                      q_full;
    logic                      q_empty;
    logic [CW-1:0]             q_count;
    logic [CW-1:0]             count_next;
    logic                      active;
    logic                      running;
    logic                      push_acc;
    logic                      overflow;
    logic                      checked;
    logic                      pop;
    logic                      ret_fail;
    logic                      timeout;
    logic                      fail_now;
    logic                      pass_now;
    fail_code_t                code_n;
    logic [PC_W-1:0]           pc_n;

    assign active   = (state == ST_IDLE) || (state == ST_RUN);
    assign running  = (state == ST_RUN);
    assign push_acc = active && exp_push && !q_full;
    assign overflow = active && exp_push && q_full;
    assign checked  = running && ret_valid && !((IGNORE_R0 != 0) && (ret_reg == '0));
    assign pop      = checked && !q_empty && (head == {ret_reg, ret_data});
    assign ret_fail = checked && !pop;
    assign timeout  = running && !ret_valid && (wd == WW'(TIMEOUT - 1));
    assign count_next = q_count + CW'(push_acc) - CW'(pop);
    assign exp_full = q_full;

    retire_exp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REG_W + DATA_W)
    ) u_fifo (
        .clk   (sysclk),
        .reset (reset),
        .push  (push_acc),
        .pop   (pop),
        .din   ({exp_reg, exp_data}),
        .head  (head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // Same-cycle priority: retire failure, overflow, timeout, end-of-test.
    always_comb begin
        fail_now = 1'b0;
        pass_now = 1'b0;
        code_n   = FAIL_NONE;
        pc_n     = '0;
        if (ret_fail) begin
            fail_now = 1'b1;
            code_n   = q_empty ? FAIL_UNEXPECTED : FAIL_MISMATCH;
            pc_n     = ret_pc;
        end else if (overflow) begin
            fail_now = 1'b1;
            code_n   = FAIL_OVERFLOW;
        end else if (timeout) begin
            fail_now = 1'b1;
            code_n   = FAIL_TIMEOUT;
        end else if (running && end_of_test) begin
            if (count_next == '0) begin
                pass_now = 1'b1;
            end else begin
                fail_now = 1'b1;
                code_n   = FAIL_LEFTOVER;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wd         <= '0;
            pass_count <= '0;
            fail_code  <= FAIL_NONE;
            fail_pc    <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            if (running) begin
                wd <= ret_valid ? '0 : wd + WW'(1);
                if (pop && (pass_count != '1)) pass_count <= pass_count + 16'd1;
            end
            if (fail_now) begin
                state     <= ST_FAIL;
                fail_code <= code_n;
                fail_pc   <= pc_n;
                done      <= 1'b1;
                error     <= 1'b1;
            end else if (pass_now) begin
                state <= ST_PASS;
                done  <= 1'b1;
            end else if ((state == ST_IDLE) && start) begin
                state <= ST_RUN;
            end
        end
    end

endmodule

// File: doc/retire_checker.md
Name: retire_checker

Overview:
- Self-checking monitor that sits directly downstream of the single-cycle CPU in simulation.
- Consumes the CPU's per-cycle register-writeback (retire) stream and compares it in order against an expected-result queue loaded by the bench.
- Drives the bench's `error` output, plus done/status for regression scripting.
- Synthesisable so the same checker can run on FPGA bring-up.

Parameters:
- DEPTH, 16, expected-queue entries (power of two, ≥2).
- TIMEOUT, 64, consecutive RUN cycles without a retire before failing.
- IGNORE_R0, 1, when 1, retires targeting r0 are neither compared nor consumed.

Ports:
- sysclk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- exp_push  in  1  enqueue expected entry this cycle.
- exp_reg  in  5  expected destination register.
- exp_data  in  32  expected writeback value.
- exp_full  out  1  queue full (registered state).
- start  in  1  pulse: begin checking.
- end_of_test  in  1  pulse: bench declares program finished.
- ret_valid  in  1  CPU wrote a register this cycle.
- ret_pc  in  32  PC of retiring instruction.
- ret_reg  in  5  destination register written.
- ret_data  in  32  value written.
- pass_count  out  16  matched retires, saturating at 16'hFFFF.
- fail_code  out  3  0 none, 1 mismatch, 2 unexpected retire, 3 timeout, 4 leftover entries, 5 overflow.
- fail_pc  out  32  ret_pc of the failing retire; 0 for codes 3/4/5.
- done  out  1  high in PASS or FAIL.
- error  out  1  high in FAIL.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, queue empty, exp_full 0, pass_count 0, fail_code 0, fail_pc 0, done 0, error 0, watchdog 0.
- Reset mid-operation discards all queue contents and status, same cycle.
- FSM states: IDLE, RUN, PASS, FAIL.
  - IDLE: ret_valid is ignored. start → RUN on the next edge.
  - RUN, a retire is "checked" when ret_valid && !(IGNORE_R0 && ret_reg==0):
    - queue empty → FAIL, code 2, fail_pc=ret_pc.
    - head reg and data both equal → pop, pass_count+1.
    - otherwise → FAIL, code 1, fail_pc=ret_pc; head is not popped.
  - RUN, end_of_test (evaluated after any same-cycle retire):
    - queue empty after that retire → PASS.
    - else → FAIL, code 4.
    - A retire that fails in the same cycle takes precedence; its code is kept.
  - Watchdog:
    - Counts RUN cycles with ret_valid low; clears on any ret_valid, including ignored r0 writes.
    - On the edge where the count reaches TIMEOUT → FAIL, code 3.
  - PASS and FAIL are terminal until reset. start, ret_valid, end_of_test and exp_push are ignored there.
- Queue:
  - Synchronous FIFO, pointers carry one extra wrap bit, full/empty derived from pointer compare.
  - exp_push accepted in IDLE and RUN when not full.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - exp_push while exp_full (registered) is never accepted, even if a pop occurs that cycle. It forces FAIL, code 5, from IDLE or RUN.
  - Head entry is read combinationally from storage for comparison; no extra latency.
- Latency: status reflects a retire on the edge following the retire cycle.
- First failure wins. fail_code and fail_pc never change after entering FAIL.
- If end_of_test and start pulse together in IDLE, end_of_test is ignored.

Decomposition:
- Shared package `retire_check_pkg`:
  - state encoding (2-bit).
  - fail_code constants (FAIL_NONE…FAIL_OVERFLOW).
  - field widths (REG_W=5, DATA_W=32, PC_W=32).
- One sub-module, `retire_exp_fifo`:
  - parameterised DEPTH/width synchronous FIFO.
  - push/pop/head/full/empty.
  - synchronous active-high reset.
- FSM, watchdog and counters live in `retire_checker`.

Test Plan:
- Match: push (r1,5),(r2,7); start; retire r1=5 @pc 0, r2=7 @pc 4; end_of_test → PASS, pass_count=2, error=0, fail_code=0.
- Mismatch: push (r3,0x10); start; retire r3=0x11 @pc 0x8 → FAIL next edge, fail_code=1, fail_pc=0x8, pass_count=0; later retires do not change status.
- r0 and unexpected retire: push (r4,1); start; retire r0=9, then r4=1, then r5=2 @pc 0xC → FAIL, code 2, fail_pc=0xC, pass_count=1.
- Timeout/leftover: with TIMEOUT=64 and one entry queued, start with no retires → FAIL code 3 exactly 64 edges after entering RUN. Separate run: end_of_test with one entry left → code 4.
- Overflow and wrap:
  - push 16 entries → exp_full=1; push a 17th → FAIL code 5.
  - After reset: push 16, retire 16 matching while pushing 8 more (pointer wrap); then 8 matching retires and end_of_test → PASS, pass_count=24.
- Reset mid-run: 3 entries queued, 1 matched; assert reset one cycle → all outputs at reset values, queue empty; new sequence passes normally.
